// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants for the decode-stage register file: default sizes,
// architectural register names and the "no register" index.
package regfile_scoreboard_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_NREGS  = 15;
  localparam int DEF_RIDX_W = 4;
  localparam int DEF_NRD    = 2;
  localparam int DEF_NWR    = 2;
  localparam int DEF_CNT_W  = 2;

  localparam logic [3:0] RRAX  = 4'd0;
  localparam logic [3:0] RRCX  = 4'd1;
  localparam logic [3:0] RRDX  = 4'd2;
  localparam logic [3:0] RRBX  = 4'd3;
  localparam logic [3:0] RRSP  = 4'd4;
  localparam logic [3:0] RRBP  = 4'd5;
  localparam logic [3:0] RRSI  = 4'd6;
  localparam logic [3:0] RRDI  = 4'd7;
  localparam logic [3:0] RR8   = 4'd8;
  localparam logic [3:0] RR9   = 4'd9;
  localparam logic [3:0] RR10  = 4'd10;
  localparam logic [3:0] RR11  = 4'd11;
  localparam logic [3:0] RR12  = 4'd12;
  localparam logic [3:0] RR13  = 4'd13;
  localparam logic [3:0] RR14  = 4'd14;
  localparam logic [3:0] RNONE = 4'd15;

endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// In-flight write counter for one register: adds issues, subtracts
// write-backs, clamps at zero and saturates at the counter maximum.
module sb_counter #(
  parameter int CNT_W  = 2,
  parameter int STEP_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic [STEP_W-1:0] inc_i,
  input  logic [STEP_W-1:0] dec_i,
  output logic [CNT_W-1:0]  cnt_o
);

  localparam int SUM_W = ((CNT_W > STEP_W) ? CNT_W : STEP_W) + 1;
  localparam logic [SUM_W-1:0] MAX = SUM_W'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [SUM_W-1:0] w_sum;
  logic [CNT_W-1:0] w_next;

  // untracked write-backs are legal, so more decrements than count clamp to zero
  always_comb begin
    w_sum = SUM_W'(r_cnt) + SUM_W'(inc_i);
    if (SUM_W'(dec_i) >= w_sum)
      w_next = '0;
    else if ((w_sum - SUM_W'(dec_i)) > MAX)
      w_next = CNT_W'(MAX);
    else
      w_next = CNT_W'(w_sum - SUM_W'(dec_i));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_cnt <= '0;
    else if (clr_i)
      r_cnt <= '0;
    else
      r_cnt <= w_next;
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with write-through bypass and a per-register
// pending-write scoreboard used by decode to stall on outstanding results.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NREGS    = DEF_NREGS,
  parameter int RIDX_W   = DEF_RIDX_W,
  parameter int NONE_IDX = int'(RNONE),
  parameter int NRD      = DEF_NRD,
  parameter int NWR      = DEF_NWR,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NRD*RIDX_W-1:0] rd_idx_i,
  output logic [NRD*DATA_W-1:0] rd_data_o,
  output logic [NRD-1:0]        rd_pending_o,
  input  logic [NWR*RIDX_W-1:0] wr_idx_i,
  input  logic [NWR*DATA_W-1:0] wr_data_i,
  input  logic                  iss_valid_i,
  input  logic [NWR*RIDX_W-1:0] iss_idx_i,
  output logic                  iss_ready_o,
  input  logic                  flush_i
);

  localparam int STEP_W = $clog2(NWR + 1);
  localparam int CMP_W  = ((CNT_W > STEP_W) ? CNT_W : STEP_W) + 2;
  localparam logic [CMP_W-1:0] CNT_MAX = CMP_W'((1 << CNT_W) - 1);

  logic [DATA_W-1:0] r_regs  [NREGS];
  logic [STEP_W-1:0] w_dec   [NREGS];
  logic [STEP_W-1:0] w_slots [NREGS];
  logic [STEP_W-1:0] w_inc   [NREGS];
  logic [CNT_W-1:0]  w_cnt   [NREGS];
  logic              w_ready;
  logic              w_accept;

  function automatic logic valid_idx(input logic [RIDX_W-1:0] idx);
    return (int'(idx) < NREGS) && (int'(idx) != NONE_IDX);
  endfunction

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      w_dec[r]   = '0;
      w_slots[r] = '0;
      for (int j = 0; j < NWR; j++) begin
        if (int'(wr_idx_i[j*RIDX_W +: RIDX_W]) == r)
          w_dec[r] = w_dec[r] + STEP_W'(1);
        if (int'(iss_idx_i[j*RIDX_W +: RIDX_W]) == r)
          w_slots[r] = w_slots[r] + STEP_W'(1);
      end
    end
  end

  // a same-cycle write-back frees room, so it is credited before the overflow test
  always_comb begin
    w_ready = 1'b1;
    for (int r = 0; r < NREGS; r++)
      if ((w_slots[r] != '0) &&
          ((CMP_W'(w_cnt[r]) + CMP_W'(w_slots[r])) > (CNT_MAX + CMP_W'(w_dec[r]))))
        w_ready = 1'b0;
  end

  assign w_accept    = iss_valid_i && w_ready;
  assign iss_ready_o = w_ready;

  for (genvar g = 0; g < NREGS; g++) begin : g_cnt
    assign w_inc[g] = w_accept ? w_slots[g] : '0;
    sb_counter #(
      .CNT_W  (CNT_W),
      .STEP_W (STEP_W)
    ) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (flush_i),
      .inc_i (w_inc[g]),
      .dec_i (w_dec[g]),
      .cnt_o (w_cnt[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREGS; r++)
        r_regs[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++)
        if (valid_idx(wr_idx_i[j*RIDX_W +: RIDX_W]))
          r_regs[wr_idx_i[j*RIDX_W +: RIDX_W]] <= wr_data_i[j*DATA_W +: DATA_W];
    end
  end

  // pending looks only at counters and write-back, never at issue
  always_comb begin
    rd_data_o    = '0;
    rd_pending_o = '0;
    for (int k = 0; k < NRD; k++) begin
      if (valid_idx(rd_idx_i[k*RIDX_W +: RIDX_W])) begin
        rd_data_o[k*DATA_W +: DATA_W] = r_regs[rd_idx_i[k*RIDX_W +: RIDX_W]];
        for (int j = 0; j < NWR; j++)
          if (wr_idx_i[j*RIDX_W +: RIDX_W] == rd_idx_i[k*RIDX_W +: RIDX_W])
            rd_data_o[k*DATA_W +: DATA_W] = wr_data_i[j*DATA_W +: DATA_W];
        rd_pending_o[k] = CMP_W'(w_cnt[rd_idx_i[k*RIDX_W +: RIDX_W]]) >
                          CMP_W'(w_dec[rd_idx_i[k*RIDX_W +: RIDX_W]]);
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios followed by random traffic,
// all compared against a register-array / in-flight-count reference model.
module tb_regfile_scoreboard;

  logic         clk;
  logic         rst;
  logic [7:0]   rd_idx;
  logic [127:0] rd_data;
  logic [1:0]   rd_pending;
  logic [7:0]   wr_idx_v;
  logic [127:0] wr_data_v;
  logic         iss_valid;
  logic [7:0]   iss_idx_v;
  logic         iss_ready;
  logic         flush;

  logic [3:0]  rdi    [2];
  logic [3:0]  wr_idx [2];
  logic [63:0] wr_dat [2];
  logic [3:0]  iss    [2];

  logic [63:0] m_regs [15];
  int          m_cnt  [15];

  int n_vec = 0;
  int n_err = 0;

  assign rd_idx    = {rdi[1], rdi[0]};
  assign wr_idx_v  = {wr_idx[1], wr_idx[0]};
  assign wr_data_v = {wr_dat[1], wr_dat[0]};
  assign iss_idx_v = {iss[1], iss[0]};

  regfile_scoreboard dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rd_idx_i     (rd_idx),
    .rd_data_o    (rd_data),
    .rd_pending_o (rd_pending),
    .wr_idx_i     (wr_idx_v),
    .wr_data_i    (wr_data_v),
    .iss_valid_i  (iss_valid),
    .iss_idx_i    (iss_idx_v),
    .iss_ready_o  (iss_ready),
    .flush_i      (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int n_dec(int r);
    int n = 0;
    for (int j = 0; j < 2; j++) if (int'(wr_idx[j]) == r) n++;
    return n;
  endfunction

  function automatic int n_slots(int r);
    int n = 0;
    for (int j = 0; j < 2; j++) if (int'(iss[j]) == r) n++;
    return n;
  endfunction

  // at most three writes may be in flight per register
  function automatic logic exp_ready();
    for (int r = 0; r < 15; r++)
      if (n_slots(r) > 0 && (m_cnt[r] + n_slots(r) - n_dec(r)) > 3) return 1'b0;
    return 1'b1;
  endfunction

  task automatic set_in(input logic [3:0] a0, input logic [3:0] a1,
                        input logic [3:0] w0, input logic [63:0] d0,
                        input logic [3:0] w1, input logic [63:0] d1,
                        input logic iv, input logic [3:0] s0, input logic [3:0] s1,
                        input logic fl, input logic rs);
    rdi[0] = a0; rdi[1] = a1;
    wr_idx[0] = w0; wr_dat[0] = d0;
    wr_idx[1] = w1; wr_dat[1] = d1;
    iss_valid = iv; iss[0] = s0; iss[1] = s1;
    flush = fl; rst = rs;
  endtask

  task automatic idle(input logic [3:0] a0, input logic [3:0] a1);
    set_in(a0, a1, 4'd15, 64'd0, 4'd15, 64'd0, 1'b0, 4'd15, 4'd15, 1'b0, 1'b0);
  endtask

  task automatic sample();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      int          idx = int'(rdi[k]);
      logic [63:0] ed  = 64'd0;
      logic        ep  = 1'b0;
      if (idx < 15) begin
        ed = m_regs[idx];
        for (int j = 0; j < 2; j++) if (int'(wr_idx[j]) == idx) ed = wr_dat[j];
        ep = (m_cnt[idx] - n_dec(idx)) > 0;
      end
      chk($sformatf("rd_data%0d idx=%0d", k, idx), rd_data[k*64 +: 64], ed);
      chk($sformatf("rd_pending%0d idx=%0d", k, idx), {63'd0, rd_pending[k]}, {63'd0, ep});
    end
    chk("iss_ready", {63'd0, iss_ready}, {63'd0, exp_ready()});
  endtask

  task automatic adv();
    logic acc;
    @(posedge clk);
    acc = iss_valid && exp_ready();
    if (rst) begin
      for (int r = 0; r < 15; r++) begin m_regs[r] = 64'd0; m_cnt[r] = 0; end
    end else begin
      for (int r = 0; r < 15; r++) begin
        int n = m_cnt[r] + (acc ? n_slots(r) : 0) - n_dec(r);
        m_cnt[r] = flush ? 0 : (n < 0 ? 0 : (n > 3 ? 3 : n));
      end
      for (int j = 0; j < 2; j++)
        if (int'(wr_idx[j]) < 15) m_regs[int'(wr_idx[j])] = wr_dat[j];
    end
    #1;
  endtask

  task automatic cyc();
    sample();
    adv();
  endtask

  initial begin
    idle(4'd0, 4'd0);
    rst = 1'b1;
    adv();

    // reset contents and NONE reads
    for (int i = 0; i < 15; i++) begin
      idle(4'(i), 4'(14 - i));
      sample();
      chk("reset_data", rd_data[63:0], 64'd0);
      adv();
    end
    idle(4'd15, 4'd15);
    cyc();

    // bypass and highest-port-wins
    set_in(4'd3, 4'd3, 4'd3, 64'h1234, 4'd15, 64'd0, 1'b0, 4'd15, 4'd15, 1'b0, 1'b0);
    sample();
    chk("r3_bypass", rd_data[63:0], 64'h1234);
    adv();
    idle(4'd3, 4'd4);
    sample();
    chk("r3_stored", rd_data[63:0], 64'h1234);
    adv();
    set_in(4'd4, 4'd2, 4'd4, 64'hAA, 4'd4, 64'hBB, 1'b0, 4'd15, 4'd15, 1'b0, 1'b0);
    cyc();
    idle(4'd4, 4'd3);
    sample();
    chk("r4_port1_wins", rd_data[63:0], 64'hBB);
    adv();

    // issue then write-back r5
    set_in(4'd5, 4'd15, 4'd15, 64'd0, 4'd15, 64'd0, 1'b1, 4'd5, 4'd15, 1'b0, 1'b0);
    sample();
    chk("r5_issue_not_pending", {63'd0, rd_pending[0]}, 64'd0);
    adv();
    idle(4'd5, 4'd15);
    sample();
    chk("r5_pending", {63'd0, rd_pending[0]}, 64'd1);
    adv();
    set_in(4'd5, 4'd15, 4'd5, 64'h77, 4'd15, 64'd0, 1'b0, 4'd15, 4'd15, 1'b0, 1'b0);
    sample();
    chk("r5_wb_pending", {63'd0, rd_pending[0]}, 64'd0);
    chk("r5_wb_data", rd_data[63:0], 64'h77);
    adv();
    idle(4'd5, 4'd15);
    cyc();

    // saturate r2
    for (int i = 0; i < 3; i++) begin
      set_in(4'd2, 4'd15, 4'd15, 64'd0, 4'd15, 64'd0, 1'b1, 4'd2, 4'd15, 1'b0, 1'b0);
      cyc();
    end
    set_in(4'd2, 4'd15, 4'd15, 64'd0, 4'd15, 64'd0, 1'b1, 4'd2, 4'd15, 1'b0, 1'b0);
    sample();
    chk("r2_full_ready", {63'd0, iss_ready}, 64'd0);
    adv();
    set_in(4'd2, 4'd15, 4'd2, 64'h22, 4'd15, 64'd0, 1'b1, 4'd2, 4'd15, 1'b0, 1'b0);
    sample();
    chk("r2_wb_ready", {63'd0, iss_ready}, 64'd1);
    adv();
    set_in(4'd2, 4'd15, 4'd15, 64'd0, 4'd15, 64'd0, 1'b1, 4'd2, 4'd15, 1'b0, 1'b0);
    sample();
    chk("r2_still_full", {63'd0, iss_ready}, 64'd0);
    adv();

    // flush with same-cycle write and discarded issue
    set_in(4'd1, 4'd6, 4'd15, 64'd0, 4'd15, 64'd0, 1'b1, 4'd1, 4'd6, 1'b0, 1'b0);
    cyc();
    set_in(4'd1, 4'd6, 4'd6, 64'h9, 4'd15, 64'd0, 1'b1, 4'd1, 4'd15, 1'b1, 1'b0);
    cyc();
    idle(4'd1, 4'd6);
    sample();
    chk("flush_r1_pending", {63'd0, rd_pending[0]}, 64'd0);
    chk("flush_r6_pending", {63'd0, rd_pending[1]}, 64'd0);
    chk("flush_r6_data", rd_data[127:64], 64'h9);
    adv();

    // mid-operation reset
    set_in(4'd7, 4'd8, 4'd8, 64'h55, 4'd15, 64'd0, 1'b1, 4'd7, 4'd7, 1'b0, 1'b0);
    cyc();
    set_in(4'd7, 4'd8, 4'd8, 64'h66, 4'd15, 64'd0, 1'b1, 4'd7, 4'd15, 1'b0, 1'b1);
    adv();
    idle(4'd7, 4'd8);
    sample();
    chk("rst_r7_pending", {63'd0, rd_pending[0]}, 64'd0);
    chk("rst_r8_data", rd_data[127:64], 64'd0);
    chk("rst_ready", {63'd0, iss_ready}, 64'd1);
    adv();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) rdi[k] = 4'($urandom_range(0, 15));
      for (int j = 0; j < 2; j++) begin
        wr_idx[j] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
        if ($urandom_range(0, 1) == 0) wr_idx[j] = 4'd15;
        wr_dat[j] = {$urandom, $urandom};
        iss[j] = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      end
      iss_valid = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 99) == 0);
      if (rst) adv();
      else cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the decode-stage register file: NRD read ports and NWR write ports; write-through bypass; per-register pending-write scoreboard.
- Sits in decode. Issue ports mark destinations in flight; write-back ports retire them.
- Decode uses rd_pending_o to stall on load-use and multi-cycle hazards instead of relying only on external forwarding muxes.

Parameters:
- DATA_W, 64, register width
- NREGS, 15, architectural registers (indices 0..NREGS-1)
- RIDX_W, 4, register index width
- NONE_IDX, 15, "no register" index (RNONE); must be >= NREGS
- NRD, 2, read ports
- NWR, 2, write ports (also issue ports)
- CNT_W, 2, scoreboard counter width; max in-flight writes per register = 2^CNT_W-1

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- rd_idx_i  in  NRD*RIDX_W  read indices, port k at bits [k*RIDX_W +: RIDX_W]
- rd_data_o  out  NRD*DATA_W  read data, bypassed
- rd_pending_o  out  NRD  read register still has an outstanding write after this cycle's write-back
- wr_idx_i  in  NWR*RIDX_W  write-back indices; NONE_IDX = no write
- wr_data_i  in  NWR*DATA_W  write-back data
- iss_valid_i  in  1  issue strobe for this cycle's destinations
- iss_idx_i  in  NWR*RIDX_W  destinations being issued; NONE_IDX = unused slot
- iss_ready_o  out  1  issue will be accepted
- flush_i  in  1  clear scoreboard (mispredict or pipeline squash)

Behaviour:
- Reset: all registers and counters are 0 on the first rising edge with rst_i=1. rst_i has priority over everything. Afterwards: rd_data_o=0, rd_pending_o=0, iss_ready_o=1.
- Write: on posedge, each port j with wr_idx_j<NREGS writes wr_data_j. Same index on several ports: highest j wins. Indices >= NREGS are ignored.
- Read (combinational):
  - rd_idx = NONE_IDX or >= NREGS: data 0, pending 0.
  - Otherwise, if any write port targets the same index this cycle: data of the highest such j (write-through bypass).
  - Otherwise: stored value.
- Scoreboard: one CNT_W counter per register.
  - Next value = cnt + inc - dec.
  - inc = number of issue slots naming the register when the issue is accepted.
  - dec = number of write ports naming it.
- Issue acceptance: iss_valid_i && iss_ready_o.
- iss_ready_o = 0 when, for any issue slot naming a register, cnt + (slots naming that register) - dec would exceed 2^CNT_W-1. A rejected issue changes nothing; the requester holds.
- Underflow: dec > cnt+inc clamps to 0. Untracked writes are legal.
- rd_pending_o[k] = (cnt[idx] - dec[idx], clamped at 0) != 0. Same-cycle issues do not affect pending.
- Same-cycle issue and write-back to one register: net change inc-dec; the write data still commits.
- flush_i: all counters become 0 next edge. Same-cycle issues are discarded. Writes still commit. rst_i overrides flush_i.
- Latency: write visible to reads in the same cycle (bypass) and in all later cycles. Counter updates visible the next cycle.
- No combinational path from iss_* to rd_*.

Decomposition:
- Shared package/include: RNONE/NONE_IDX, register index constants (RRSP etc.), DATA_W default. Reuse the existing define file's names.
- One sub-module: sb_counter (single CNT_W saturating up/down counter with clamp, clear and reset), instantiated NREGS times via generate.
- Storage array, bypass muxes and the ready computation stay in the top.

Test Plan:
- Reset, then read idx 0..14 on both ports -> rd_data_o=0 and rd_pending_o=0. Read NONE_IDX -> 0.
- Write 0x1234 to r3 on port0 with rd_idx0=3 in the same cycle -> rd_data_o=0x1234 that cycle and the next. Ports 0 and 1 both write r4 (0xAA, 0xBB) -> r4 reads 0xBB.
- Issue r5, then next cycle read r5 -> pending=1. Write-back r5 with data 0x77 -> pending=0 and data 0x77 in that cycle. Counter back to 0 afterwards.
- CNT_W=2: issue r2 three times, then attempt a fourth -> iss_ready_o=0 and counter stays 3. A write-back of r2 in the same cycle as the fourth issue -> iss_ready_o=1 and counter stays 3.
- Issue r1 and r6, assert flush_i with a simultaneous write r6=0x9 -> next cycle both pending=0 and r6=0x9. Issue during the flush cycle is discarded.
- Mid-operation rst_i with counters nonzero and a simultaneous write -> all registers and counters 0 next cycle, write dropped, iss_ready_o=1.
